// File: rtl/debug_link_pkg.sv
// Shared constants and types for the 40-bit debug link (sender, receiver, bench).
package debug_link_pkg;

  localparam int DBG_WORD_W       = 40;
  localparam int DBG_CNT_W        = 16;
  localparam int DBG_FRAME_PERIOD = 46;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/debug_rx_hold.sv
// One-entry holding register for received words: push/pop with drop-on-full
// and a registered one-cycle overrun pulse.
import debug_link_pkg::*;

module debug_rx_hold #(
  parameter int DATA_W = DBG_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              overrun_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              load;

  // A pop on the same edge frees the slot, so a full register can still take a push.
  always_comb begin
    load      = push_i && (!valid_q || pop_ready_i);
    data_d    = load ? push_data_i : data_q;
    valid_d   = load || (valid_q && !pop_ready_i);
    overrun_d = push_i && !load;
  end

  // NOTE: registers take non-blocking (<=) updates so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/debug_data_receiver.sv
// Deserialiser for the 40-bit debug link: strobe-framed, MSB first, one bit per clk.
// Optional saturating statistics counters when DEBUG_RX_STATS_EN is defined.
import debug_link_pkg::*;

module debug_data_receiver #(
  parameter int DATA_W = DBG_WORD_W
`ifdef DEBUG_RX_STATS_EN
  , parameter int CNT_W = DBG_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  input  logic              frame_start,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              overrun,
  output logic              frame_err
`ifdef DEBUG_RX_STATS_EN
  , output logic [CNT_W-1:0] frame_count
  , output logic [CNT_W-1:0] drop_count
`endif
);

  localparam int                   BIT_CNT_W = $clog2(DATA_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_W - 1);

  rx_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  // Only DATA_W-1 bits are stored; the last bit comes straight from sin.
  logic [DATA_W-2:0]    sr_q, sr_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push;
  logic [DATA_W-1:0]    push_data;

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    // A strobe always wins, even on the completing edge of the current frame.
    if (frame_start) begin
      frame_err_d = (state_q == RX_SHIFT);
      state_d     = RX_SHIFT;
      cnt_d       = BIT_CNT_W'(1);
      sr_d        = {{(DATA_W-2){1'b0}}, sin};
    end else if (state_q == RX_SHIFT) begin
      sr_d = {sr_q[DATA_W-3:0], sin};
      if (cnt_q == LAST_BIT) begin
        push    = 1'b1;
        state_d = RX_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + BIT_CNT_W'(1);
      end
    end
  end

  assign push_data = {sr_q, sin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: the shift register is pure datapath that each strobe reloads, so it
  // carries no reset; only control state needs a known value.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  debug_rx_hold #(.DATA_W(DATA_W)) u_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_ready_i (out_ready),
    .data_o      (out_data),
    .valid_o     (out_valid),
    .overrun_o   (overrun)
  );

  assign busy      = (state_q == RX_SHIFT);
  assign frame_err = frame_err_q;

`ifdef DEBUG_RX_STATS_EN
  logic             stat_load, stat_drop;
  logic [CNT_W-1:0] frame_count_q, drop_count_q;

  // Mirrors the holding register's load/drop decision for the same edge.
  assign stat_load = push && (!out_valid || out_ready);
  assign stat_drop = push && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      if (stat_load && !(&frame_count_q)) frame_count_q <= frame_count_q + CNT_W'(1);
      if (stat_drop && !(&drop_count_q))  drop_count_q  <= drop_count_q + CNT_W'(1);
    end
  end

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
`endif

endmodule

// File: tb/tb_debug_data_receiver.sv
// Bench for debug_data_receiver: table-driven frames plus abort and reset sequences,
// with a scoreboard of expected words checked whenever the consumer pops.
import debug_link_pkg::*;

module tb_debug_data_receiver;

  localparam int W   = DBG_WORD_W;
  localparam int GAP = DBG_FRAME_PERIOD - DBG_WORD_W;

  typedef logic [W-1:0] word_t;

  typedef struct {
    word_t word;
    logic  rdy_body;
    logic  rdy_last;
    logic  exp_valid_pre;
    logic  exp_valid;
    word_t exp_data;
    logic  exp_overrun;
    logic  exp_delivered;
  } vec_t;

  logic  clk, rst_n, sin, frame_start, out_ready;
  word_t out_data;
  logic  out_valid, busy, overrun, frame_err;
`ifdef DEBUG_RX_STATS_EN
  logic [DBG_CNT_W-1:0] frame_count, drop_count;
`endif

  debug_data_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sin         (sin),
    .frame_start (frame_start),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun),
    .frame_err   (frame_err)
`ifdef DEBUG_RX_STATS_EN
    , .frame_count (frame_count)
    , .drop_count  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    ovr_seen = 0;
  int    err_seen = 0;
  int    exp_loads = 0;
  int    exp_drops = 0;
  word_t sb[$];
  vec_t  vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Samples just after the negedge, when the next posedge's inputs are settled.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (overrun)   ovr_seen++;
        if (frame_err) err_seen++;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) check("sb_unexpected_pop", 1, 0);
          else                check("sb_word", out_data, sb.pop_front());
        end
      end
    end
  end

  task automatic send_bits(input word_t w, input int n, input logic exp_err,
                           input logic rdy_body, input logic rdy_last,
                           input logic exp_valid_pre);
    for (int k = 0; k < n; k++) begin
      frame_start = (k == 0);
      sin         = w[W-1-k];
      out_ready   = (k == W-1) ? rdy_last : rdy_body;
      @(negedge clk);
      if (k == 0) begin
        check("frame_err_at_strobe", frame_err, exp_err);
        check("busy_at_strobe", busy, 1);
      end
      if (n == W && k == W-2) check("valid_before_last", out_valid, exp_valid_pre);
    end
    frame_start = 1'b0;
    sin         = 1'b0;
  endtask

  task automatic idle(input int n);
    frame_start = 1'b0;
    sin         = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{40'hA5_1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 40'hA5_1234_5678, 1'b0, 1'b1};
    vecs[1] = '{40'hFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 40'hFF_FFFF_FFFF, 1'b0, 1'b1};
    vecs[2] = '{40'h00_0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 40'hFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[3] = '{40'h80_0000_0001, 1'b0, 1'b1, 1'b1, 1'b1, 40'h80_0000_0001, 1'b0, 1'b1};
    vecs[4] = '{40'h5A_DEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1, 40'h5A_DEAD_BEEF, 1'b0, 1'b1};

    rst_n = 1'b0; sin = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
`ifdef DEBUG_RX_STATS_EN
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);
`endif
    rst_n = 1'b1;

    // Line activity without a strobe must be ignored.
    for (int i = 0; i < 8; i++) begin
      sin = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_busy", busy, 0);
    end
    check("idle_valid", out_valid, 0);
    idle(2);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].exp_delivered) sb.push_back(vecs[i].word);
      send_bits(vecs[i].word, W, 1'b0, vecs[i].rdy_body, vecs[i].rdy_last, vecs[i].exp_valid_pre);
      check("valid_after_last", out_valid, vecs[i].exp_valid);
      check("data_after_last", out_data, vecs[i].exp_data);
      check("overrun_after_last", overrun, vecs[i].exp_overrun);
      check("frame_err_after_last", frame_err, 0);
      if (vecs[i].exp_overrun) exp_drops++;
      else                     exp_loads++;
      idle(GAP);
    end
    wait_drain();
    check("table_overrun_pulses", ovr_seen, 1);
`ifdef DEBUG_RX_STATS_EN
    check("table_frame_count", frame_count, exp_loads);
    check("table_drop_count", drop_count, exp_drops);
`endif

    // New strobe at edge 20 aborts the frame in progress.
    sb.push_back(40'h0F_0F0F_0F0F);
    send_bits(40'h12_3456_789A, 20, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(40'h0F_0F0F_0F0F, W, 1'b1, 1'b1, 1'b1, 1'b0);
    check("abort20_data", out_data, 40'h0F_0F0F_0F0F);
    exp_loads++;
    idle(GAP);
    wait_drain();

    // Strobe on the completing edge: the aborted word must never appear.
    sb.push_back(40'h33_CC33_CC33);
    send_bits(40'hFE_DCBA_9876, W-1, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bits(40'h33_CC33_CC33, W, 1'b1, 1'b1, 1'b1, 1'b0);
    check("abort39_data", out_data, 40'h33_CC33_CC33);
    exp_loads++;
    idle(GAP);
    wait_drain();
    check("abort_err_pulses", err_seen, 2);
`ifdef DEBUG_RX_STATS_EN
    check("abort_frame_count", frame_count, exp_loads);
`endif

    // Reset at edge 15 of a frame while a word is held.
    send_bits(40'hC3_C3C3_C3C3, W, 1'b0, 1'b0, 1'b0, 1'b0);
    check("held_valid", out_valid, 1);
    idle(GAP);
    send_bits(40'h11_2233_4455, 15, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", out_data, 0);
`ifdef DEBUG_RX_STATS_EN
    check("midrst_frame_count", frame_count, 0);
    check("midrst_drop_count", drop_count, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("postrst_busy", busy, 0);
    sb.push_back(40'h96_6996_6996);
    send_bits(40'h96_6996_6996, W, 1'b0, 1'b1, 1'b1, 1'b0);
    check("postrst_data", out_data, 40'h96_6996_6996);
    idle(GAP);
    wait_drain();
`ifdef DEBUG_RX_STATS_EN
    check("postrst_frame_count", frame_count, 1);
    check("postrst_drop_count", drop_count, 0);
`endif
    check("total_overrun_pulses", ovr_seen, 1);
    check("total_frame_err_pulses", err_seen, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
